// File: rtl/spi_fifo_pkg.sv
// Shared widths and the interrupt flag bundle for the SPI data FIFOs.
package spi_fifo_pkg;

  localparam int unsigned SPI_DATA_WIDTH    = 32;
  localparam int unsigned SPI_POINTER_WIDTH = 6;
  localparam int unsigned SPI_FIFO_DEPTH    = 1 << SPI_POINTER_WIDTH;

  typedef struct packed {
    logic fifo_full;
    logic fifo_empty;
    logic fifo_overflow;
    logic fifo_underflow;
  } fifo_interrupt_t;

endpackage

// File: rtl/spi_fifo_mem.sv
// FIFO storage: synchronous write port and registered read port, no reset on the array
// so it can map onto an SRAM macro.
module spi_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_fifo.sv
// Single-clock SPI data FIFO: wrap-bit pointers, sticky overflow/underflow, fill level.
module spi_fifo
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = SPI_DATA_WIDTH,
  parameter int unsigned POINTER_WIDTH = SPI_POINTER_WIDTH
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   fifo_clear,
  input  logic                   err_clr,
  input  logic                   wen,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   ren,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic [POINTER_WIDTH:0] fifo_level,
  output fifo_interrupt_t        fifo_intr
);

  localparam logic [POINTER_WIDTH:0] PtrOne = (POINTER_WIDTH+1)'(1);

  logic [POINTER_WIDTH:0] wptr_q, wptr_d;
  logic [POINTER_WIDTH:0] rptr_q, rptr_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   rvalid_q, rvalid_d;
  logic                   full, empty, flush, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  always_comb begin
    flush = preset | fifo_clear;
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[POINTER_WIDTH] != rptr_q[POINTER_WIDTH]) &&
            (wptr_q[POINTER_WIDTH-1:0] == rptr_q[POINTER_WIDTH-1:0]);
    wr_ok = wen & ~full & ~flush;
    rd_ok = ren & ~empty & ~flush;
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    rvalid_d = rvalid_q;
    if (fifo_clear) begin
      wptr_d   = '0;
      rptr_d   = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      rvalid_d = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + PtrOne;
      if (rd_ok) rptr_d = rptr_q + PtrOne;
      // A new error event wins over err_clr in the same cycle.
      ovf_d    = (wen & full) | (ovf_q & ~err_clr);
      udf_d    = (ren & empty) | (udf_q & ~err_clr);
      rvalid_d = rvalid_q | rd_ok;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rvalid_q <= rvalid_d;
    end
  end

  spi_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(POINTER_WIDTH)
  ) u_mem (
    .clk  (pclk),
    .we   (wr_ok),
    .waddr(wptr_q[POINTER_WIDTH-1:0]),
    .wdata(wdata),
    .re   (rd_ok),
    .raddr(rptr_q[POINTER_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  // The read register is not reset, so rdata reads zero until the first read after a flush.
  assign rdata      = rvalid_q ? mem_rdata : '0;
  assign fifo_level = wptr_q - rptr_q;

  always_comb begin
    fifo_intr.fifo_full      = full;
    fifo_intr.fifo_empty     = empty;
    fifo_intr.fifo_overflow  = ovf_q;
    fifo_intr.fifo_underflow = udf_q;
  end

endmodule

// File: tb/tb_spi_fifo.sv
// Bench for spi_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_spi_fifo;
  import spi_fifo_pkg::*;

  logic            pclk = 1'b0;
  logic            preset, fifo_clear, err_clr, wen, ren;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [6:0]      fifo_level;
  fifo_interrupt_t fifo_intr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic [31:0] m_rdata;
  logic        m_ovf, m_udf;

  always #5 pclk = ~pclk;

  spi_fifo dut (
    .pclk      (pclk),
    .preset    (preset),
    .fifo_clear(fifo_clear),
    .err_clr   (err_clr),
    .wen       (wen),
    .wdata     (wdata),
    .ren       (ren),
    .rdata     (rdata),
    .fifo_level(fifo_level),
    .fifo_intr (fifo_intr)
  );

  wire [42:0] dut_vec = {rdata, fifo_level, fifo_intr};

  function automatic logic [42:0] exp_vec();
    return {m_rdata, 7'(q.size()), q.size() == 64, q.size() == 0, m_ovf, m_udf};
  endfunction

  // Drive one cycle of inputs, advance DUT and model together, return #1 after the edge.
  task automatic tick(input logic w, input logic [31:0] d, input logic r,
                      input logic clr = 1'b0, input logic ec = 1'b0, input logic rst = 1'b0);
    bit was_full, was_empty;
    preset = rst; fifo_clear = clr; err_clr = ec; wen = w; wdata = d; ren = r;
    @(posedge pclk);
    if (rst || clr) begin
      q.delete();
      m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      was_full  = (q.size() == 64);
      was_empty = (q.size() == 0);
      if (r && !was_empty) m_rdata = q.pop_front();
      if (w && !was_full) q.push_back(d);
      m_ovf = (w && was_full) ? 1'b1 : (ec ? 1'b0 : m_ovf);
      m_udf = (r && was_empty) ? 1'b1 : (ec ? 1'b0 : m_udf);
    end
    #1;
    preset = 0; fifo_clear = 0; err_clr = 0; wen = 0; ren = 0;
  endtask

  task automatic test_reset();
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec !== {32'h0, 7'd0, 4'b0100}) begin
      n_fail++;
      $display("FAIL reset: got %h required %h", dut_vec, {32'h0, 7'd0, 4'b0100});
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) tick(1'b1, 32'hA5A5_0000 + 32'(i), 1'b0);
    n_checks++;
    if (fifo_level !== 7'd3 || fifo_intr.fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_level: got level %0d empty %b required 3/0", fifo_level,
               fifo_intr.fifo_empty);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, '0, 1'b1);
      n_checks++;
      if (rdata !== 32'hA5A5_0000 + 32'(i) || dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_read%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (fifo_level !== 7'd0 || fifo_intr.fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drain: got level %0d empty %b", fifo_level, fifo_intr.fifo_empty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 65; i++) begin
      tick(1'b1, 32'(i), 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_w%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (fifo_level !== 7'd64 || fifo_intr !== 4'b1010) begin
      n_fail++;
      $display("FAIL fill_overflow: got level %0d intr %b required 64/1010", fifo_level,
               fifo_intr);
    end
    for (int i = 0; i < 64; i++) begin
      tick(1'b0, '0, 1'b1);
      n_checks++;
      if (rdata !== 32'(i) || dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_r%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 64; i++) tick(1'b1, 32'h100 + 32'(i), 1'b0);
    tick(1'b1, 32'hDEAD_BEEF, 1'b1);
    n_checks++;
    if (rdata !== 32'h100 || fifo_level !== 7'd63 || fifo_intr.fifo_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rw: got rdata %h level %0d ovf %b required 100/63/1", rdata,
               fifo_level, fifo_intr.fifo_overflow);
    end
    for (int i = 0; i < 63; i++) begin
      tick(1'b0, '0, 1'b1);
      n_checks++;
      if (rdata === 32'hDEAD_BEEF || dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_rw_drain%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_underflow();
    logic [31:0] held;
    held = m_rdata;
    tick(1'b0, '0, 1'b1);
    n_checks++;
    if (fifo_intr.fifo_underflow !== 1'b1 || rdata !== held) begin
      n_fail++;
      $display("FAIL udf_set: got udf %b rdata %h required 1/%h", fifo_intr.fifo_underflow,
               rdata, held);
    end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (fifo_intr.fifo_underflow !== 1'b0 || fifo_intr.fifo_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clr: got intr %b required x100", fifo_intr);
    end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (fifo_intr.fifo_underflow !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL udf_set_wins: got %h required %h", dut_vec, exp_vec());
    end
    // Write while empty with a read: write accepted, read rejected, no bypass.
    tick(1'b1, 32'h0BAD_F00D, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec() || fifo_level !== 7'd1 || rdata === 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL empty_rw: got %h required %h", dut_vec, exp_vec());
    end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, $urandom, 1'b0);
      tick(1'b0, '0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_clear(input logic use_reset);
    logic [31:0] v;
    for (int i = 0; i < 10; i++) tick(1'b1, $urandom, 1'b0);
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 32'h1234_5678, 1'b1, !use_reset, 1'b0, use_reset);
    n_checks++;
    if (dut_vec !== {32'h0, 7'd0, 4'b0100}) begin
      n_fail++;
      $display("FAIL clear_%0d: got %h required %h", use_reset, dut_vec,
               {32'h0, 7'd0, 4'b0100});
    end
    v = $urandom;
    tick(1'b1, v, 1'b0);
    tick(1'b0, '0, 1'b1);
    n_checks++;
    if (rdata !== v || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL clear_fresh_%0d: got %h required %h", use_reset, dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int fill_bias;
    for (int i = 0; i < 3000; i++) begin
      fill_bias = ((i / 500) % 2 == 0) ? 70 : 35;
      tick($urandom_range(0, 99) < fill_bias, $urandom, $urandom_range(0, 99) < 50,
           $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_underflow();
    test_stream();
    test_clear(1'b0);
    test_clear(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
